rat_ctrl: RTL and testbench



---
 rtl/rat_ctrl.sv | 135 +++++++++++++
 tb/tb_rat_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rat_ctrl.sv
// Rename alias table controller: init walk, 4-slot rename writes, flush restore.
// Define RAT_CTRL_IDENTITY_INIT_EN to init entry i with i, else with INITVALUE.
module rat_ctrl #(
    parameter int DATAWIDTH = 8,
    parameter int INDEXSIZE = 64,
    parameter int LOGINDEX  = 6,
    parameter int INITVALUE = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [3:0]             ren_valid_in,
    input  logic [4*LOGINDEX-1:0]  ren_idx_in,
    input  logic [4*DATAWIDTH-1:0] ren_data_in,
    input  logic                   flush_in,
    output logic [8*LOGINDEX-1:0]  cmap_idx_out,
    input  logic [8*DATAWIDTH-1:0] cmap_data_in,
    output logic [7:0]             ram_we_out,
    output logic [8*LOGINDEX-1:0]  ram_idx_out,
    output logic [8*DATAWIDTH-1:0] ram_data_out,
    output logic                   ren_stall_out,
    output logic                   recover_done_out
);

    localparam int PW = LOGINDEX - 3;
    localparam logic [PW-1:0] LAST = PW'(INDEXSIZE / 8 - 1);
    localparam logic [DATAWIDTH-1:0] FILL = DATAWIDTH'(INITVALUE);

    typedef enum logic [1:0] {
        INIT,
        RUN,
        RECOVER
    } state_t;

    state_t        state, next_state;
    logic [PW-1:0] ptr, ptr_next;
    logic          from_rec;
    logic [3:0]    wr_ok;
    logic [8*LOGINDEX-1:0]  walk_idx;
    logic [8*DATAWIDTH-1:0] init_data;

    always_comb begin
        walk_idx  = '0;
        init_data = '0;
        for (int k = 0; k < 8; k++) begin
            walk_idx[k*LOGINDEX +: LOGINDEX] = {ptr, 3'(k)};
`ifdef RAT_CTRL_IDENTITY_INIT_EN
            init_data[k*DATAWIDTH +: DATAWIDTH] = DATAWIDTH'({ptr, 3'(k)});
`else
            init_data[k*DATAWIDTH +: DATAWIDTH] = FILL;
`endif
        end
    end

    assign cmap_idx_out = walk_idx;

    // Younger slots override older ones writing the same entry.
    always_comb begin
        wr_ok = '0;
        for (int k = 0; k < 4; k++) begin
            wr_ok[k] = ren_valid_in[k];
            for (int j = k + 1; j < 4; j++) begin
                if (ren_valid_in[j] &&
                    ren_idx_in[j*LOGINDEX +: LOGINDEX] ==
                    ren_idx_in[k*LOGINDEX +: LOGINDEX])
                    wr_ok[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= INIT;
            ptr      <= '0;
            from_rec <= 1'b0;
        end else begin
            state    <= next_state;
            ptr      <= ptr_next;
            from_rec <= (state == RECOVER) && (next_state == RUN);
        end
    end

    always_comb begin
        next_state       = state;
        ptr_next         = ptr;
        ram_we_out       = '0;
        ram_idx_out      = walk_idx;
        ram_data_out     = '0;
        ren_stall_out    = 1'b1;
        recover_done_out = 1'b0;
        unique case (state)
            INIT: begin
                ram_we_out   = 8'hFF;
                ram_data_out = init_data;
                ptr_next     = ptr + 1'b1;
                if (ptr == LAST) begin
                    next_state = RUN;
                    ptr_next   = '0;
                end
            end
            RUN: begin
                recover_done_out = from_rec;
                ram_idx_out[4*LOGINDEX-1:0]   = ren_idx_in;
                ram_data_out[4*DATAWIDTH-1:0] = ren_data_in;
                if (flush_in) begin
                    next_state = RECOVER;
                    ptr_next   = '0;
                end else begin
                    ren_stall_out   = 1'b0;
                    ram_we_out[3:0] = wr_ok;
                end
            end
            RECOVER: begin
                ram_we_out   = 8'hFF;
                ram_data_out = cmap_data_in;
                ptr_next     = ptr + 1'b1;
                if (flush_in) begin
                    ptr_next = '0;
                end else if (ptr == LAST) begin
                    next_state = RUN;
                    ptr_next   = '0;
                end
            end
            default: begin
                next_state = INIT;
                ptr_next   = '0;
            end
        endcase
        if (reset) begin
            ram_we_out       = '0;
            ren_stall_out    = 1'b1;
            recover_done_out = 1'b0;
        end
    end

endmodule

// File: tb/tb_rat_ctrl.sv
// Directed bench for rat_ctrl: init walk, rename merge, flush restore, reset.
// Expected init contents follow RAT_CTRL_IDENTITY_INIT_EN (else INITVALUE=63).
module tb_rat_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  ren_valid_in;
    logic [23:0] ren_idx_in;
    logic [31:0] ren_data_in;
    logic        flush_in;
    logic [47:0] cmap_idx_out;
    logic [63:0] cmap_data_in;
    logic [7:0]  ram_we_out;
    logic [47:0] ram_idx_out;
    logic [63:0] ram_data_out;
    logic        ren_stall_out;
    logic        recover_done_out;

    logic [7:0] mem  [64];
    logic [7:0] cmap [64];
    int n_cmp = 0;
    int n_bad = 0;

    rat_ctrl #(.INITVALUE(63)) dut (
        .clock(clock),
        .reset(reset),
        .ren_valid_in(ren_valid_in),
        .ren_idx_in(ren_idx_in),
        .ren_data_in(ren_data_in),
        .flush_in(flush_in),
        .cmap_idx_out(cmap_idx_out),
        .cmap_data_in(cmap_data_in),
        .ram_we_out(ram_we_out),
        .ram_idx_out(ram_idx_out),
        .ram_data_out(ram_data_out),
        .ren_stall_out(ren_stall_out),
        .recover_done_out(recover_done_out)
    );

    always #5 clock = ~clock;

    // Committed map RAM and 8-port map RAM models
    always_comb begin
        cmap_data_in = '0;
        for (int k = 0; k < 8; k++)
            cmap_data_in[k*8 +: 8] = cmap[cmap_idx_out[k*6 +: 6]];
    end

    always @(posedge clock) begin
        for (int k = 0; k < 8; k++)
            if (ram_we_out[k])
                mem[ram_idx_out[k*6 +: 6]] <= ram_data_out[k*8 +: 8];
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] init_val(input int i);
`ifdef RAT_CTRL_IDENTITY_INIT_EN
        return 8'(i);
`else
        return 8'd63;
`endif
    endfunction

    function automatic int init_errs();
        int e = 0;
        for (int i = 0; i < 64; i++)
            if (mem[i] !== init_val(i)) e++;
        return e;
    endfunction

    function automatic int cmap_errs();
        int e = 0;
        for (int i = 0; i < 64; i++)
            if (mem[i] !== cmap[i]) e++;
        return e;
    endfunction

    initial begin
        int bad_we, bad_idx, ncyc, first, saw_done;
        for (int i = 0; i < 64; i++) begin
            cmap[i] = 8'((i * 3 + 1) & 8'hFF);
            mem[i]  = 8'hEE;
        end
        reset = 1'b1;
        ren_valid_in = '0;
        ren_idx_in = '0;
        ren_data_in = '0;
        flush_in = 1'b0;
        #1;
        chk("rst_we", 64'(ram_we_out), 64'h0);
        chk("rst_stall", 64'(ren_stall_out), 64'h1);
        tick();
        tick();
        chk("rst_done", 64'(recover_done_out), 64'h0);
        reset = 1'b0;
        #1;

        // Init walk: 8 cycles, all ports enabled, indices ptr*8+k
        bad_we = 0;
        bad_idx = 0;
        for (int c = 0; c < 8; c++) begin
            if (ram_we_out !== 8'hFF || ren_stall_out !== 1'b1) bad_we++;
            if (ram_idx_out[5*6 +: 6] !== 6'(c * 8 + 5)) bad_idx++;
            if (recover_done_out !== 1'b0) bad_we++;
            tick();
        end
        chk("init_we", 64'(bad_we), 64'h0);
        chk("init_idx", 64'(bad_idx), 64'h0);
        chk("run_stall", 64'(ren_stall_out), 64'h0);
        chk("init_nodone", 64'(recover_done_out), 64'h0);
        chk("init_e37", 64'(mem[37]), 64'(init_val(37)));
        chk("init_all", 64'(init_errs()), 64'h0);

        // Slots 0 and 2 both write entry 5: slot 2 wins
        ren_valid_in = 4'b0101;
        ren_idx_in = {6'd0, 6'd5, 6'd0, 6'd5};
        ren_data_in = {8'd0, 8'd22, 8'd0, 8'd11};
        #1;
        chk("merge_we", 64'(ram_we_out), 64'h04);
        tick();
        ren_valid_in = '0;
        #1;
        chk("merge_e5", 64'(mem[5]), 64'd22);

        // Four distinct entries
        ren_valid_in = 4'hF;
        ren_idx_in = {6'd4, 6'd3, 6'd2, 6'd1};
        ren_data_in = {8'hA4, 8'hA3, 8'hA2, 8'hA1};
        #1;
        chk("dist_we", 64'(ram_we_out), 64'h0F);
        tick();
        chk("dist_e3", 64'(mem[3]), 64'hA3);

        // Slots 0/2 share entry 7, 1/3 share entry 9
        ren_idx_in = {6'd9, 6'd7, 6'd9, 6'd7};
        #1;
        chk("pair_we", 64'(ram_we_out), 64'h0C);
        chk("pair_idx2", 64'(ram_idx_out[2*6 +: 6]), 64'd7);

        // Flush with all slots valid: no writes, 8 restore cycles
        flush_in = 1'b1;
        #1;
        chk("flush_we", 64'(ram_we_out), 64'h0);
        chk("flush_stall", 64'(ren_stall_out), 64'h1);
        tick();
        flush_in = 1'b0;
        ren_valid_in = '0;
        #1;
        bad_we = 0;
        for (int c = 1; c <= 8; c++) begin
            if (ram_we_out !== 8'hFF || ren_stall_out !== 1'b1) bad_we++;
            if (recover_done_out !== 1'b0) bad_we++;
            tick();
        end
        chk("rec_we", 64'(bad_we), 64'h0);
        chk("rec_done9", 64'(recover_done_out), 64'h1);
        chk("rec_stall9", 64'(ren_stall_out), 64'h0);
        chk("rec_copy", 64'(cmap_errs()), 64'h0);
        tick();
        chk("rec_pulse", 64'(recover_done_out), 64'h0);

        // Dirty the map, flush, flush again in recover cycle 4
        ren_valid_in = 4'b0001;
        ren_idx_in = {18'd0, 6'd60};
        ren_data_in = 32'h55;
        tick();
        ren_valid_in = '0;
        flush_in = 1'b1;
        first = 0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            flush_in = (t == 4);
            #1;
            if (t == 4)
                chk("reflush_we", 64'(ram_we_out), 64'hFF);
            if (t == 5)
                chk("reflush_idx", 64'(ram_idx_out[0 +: 6]), 64'd0);
            if (recover_done_out === 1'b1 && first == 0) first = t;
        end
        chk("reflush_done", 64'(first), 64'd13);
        chk("reflush_copy", 64'(cmap_errs()), 64'h0);

        // Reset in recover cycle 3: full init, no done pulse
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("midrst_we", 64'(ram_we_out), 64'h0);
        chk("midrst_sig", 64'({ren_stall_out, recover_done_out}), 64'b10);
        tick();
        reset = 1'b0;
        #1;
        ncyc = 0;
        bad_we = 0;
        saw_done = 0;
        while (ren_stall_out === 1'b1 && ncyc < 20) begin
            if (ram_we_out !== 8'hFF) bad_we++;
            if (recover_done_out !== 1'b0) saw_done++;
            ncyc++;
            tick();
        end
        if (recover_done_out !== 1'b0) saw_done++;
        chk("reinit_len", 64'(ncyc), 64'd8);
        chk("reinit_we", 64'(bad_we), 64'h0);
        chk("reinit_nodone", 64'(saw_done), 64'h0);
        chk("reinit_all", 64'(init_errs()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
